// File: rtl/temporal_encoder.sv
// Binary-to-temporal source for race-logic operators: owns the gamma timebase
// and emits each accepted word as a step or pulse edge on q at tick v.
module temporal_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int VAL_WIDTH         = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic                                 aclk,
  input  logic                                 grst,
  input  logic                                 en,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [VAL_WIDTH-1:0]                 in_value,
  input  logic                                 in_mode,
  output logic                                 q,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] gamma_tick,
  output logic                                 gamma_rst,
  output logic                                 busy
);

  localparam int G  = GAMMA_CYCLE_WIDTH;
  localparam int TW = $clog2(G);
  localparam logic [TW-1:0] LAST_TICK = TW'(G - 1);
  localparam logic [31:0]   LAST_EDGE = 32'(G - 2);
  localparam logic [31:0]   PW        = 32'(PULSE_WIDTH);

  logic                 pend_valid;
  logic [VAL_WIDTH-1:0] pend_value;
  logic                 pend_mode;
  logic                 act_valid;
  logic [VAL_WIDTH-1:0] act_value;
  logic                 act_mode;

  logic                 boundary;
  logic [TW-1:0]        tick_nxt;
  logic                 act_valid_nxt;
  logic [VAL_WIDTH-1:0] act_value_nxt;
  logic                 act_mode_nxt;
  logic [31:0]          t32;
  logic [31:0]          v32;
  logic                 finite_nxt;
  logic                 q_nxt;

  assign in_ready = ~pend_valid;

  // Outputs are evaluated against the tick and active word that will be in
  // place after the edge, so q lines up with gamma_tick without latency.
  always_comb begin
    boundary      = en && (gamma_tick == LAST_TICK);
    tick_nxt      = gamma_tick;
    act_valid_nxt = act_valid;
    act_value_nxt = act_value;
    act_mode_nxt  = act_mode;
    if (en) tick_nxt = boundary ? '0 : gamma_tick + TW'(1);
    if (boundary) begin
      act_valid_nxt = pend_valid;
      act_value_nxt = pend_value;
      act_mode_nxt  = pend_mode;
    end
    t32        = 32'(tick_nxt);
    v32        = 32'(act_value_nxt);
    finite_nxt = act_valid_nxt && (v32 <= LAST_EDGE);
    q_nxt      = en && finite_nxt && (t32 >= v32) && (t32 <= LAST_EDGE) &&
                 (!act_mode_nxt || ((t32 - v32) < PW));
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      gamma_tick <= '0;
      gamma_rst  <= 1'b0;
      q          <= 1'b0;
      busy       <= 1'b0;
      pend_valid <= 1'b0;
      pend_value <= '0;
      pend_mode  <= 1'b0;
      act_valid  <= 1'b0;
      act_value  <= '0;
      act_mode   <= 1'b0;
    end else begin
      gamma_tick <= tick_nxt;
      gamma_rst  <= en && (tick_nxt == LAST_TICK);
      q          <= q_nxt;
      busy       <= finite_nxt;
      act_valid  <= act_valid_nxt;
      act_value  <= act_value_nxt;
      act_mode   <= act_mode_nxt;
      // Accept and boundary transfer never collide: accept needs pending empty.
      if (boundary) pend_valid <= 1'b0;
      if (in_valid && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_value <= in_value;
        pend_mode  <= in_mode;
      end
    end
  end

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench for temporal_encoder (G=16, P=8): a per-gamma vector table
// plus hand-written backpressure, boundary-accept, en-freeze and reset cases.
module tb_temporal_encoder;

  localparam int G  = 16;
  localparam int P  = 8;
  localparam int VW = 5;

  logic          aclk;
  logic          grst;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_value;
  logic          in_mode;
  logic          q;
  logic [3:0]    gamma_tick;
  logic          gamma_rst;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;

  temporal_encoder #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(P)) dut (
    .aclk(aclk), .grst(grst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_mode(in_mode), .q(q), .gamma_tick(gamma_tick),
    .gamma_rst(gamma_rst), .busy(busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [VW-1:0] v;
    logic          mode;
    int            qlo;
    int            qhi;
    logic          busy;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Walk ticks [start, stop) of one gamma, checking q against the expected
  // [qlo, qhi] window; optionally present a word for one cycle at send_t.
  task automatic run_gamma(input int start, input int stop, input int qlo, input int qhi,
                           input logic exp_busy, input int send_t,
                           input logic [VW-1:0] v, input logic mode);
    for (int t = start; t < stop; t++) begin
      chk($sformatf("tick@%0d", t), 32'(gamma_tick), 32'(t));
      chk($sformatf("q@%0d", t), 32'(q), 32'(t >= qlo && t <= qhi));
      chk($sformatf("busy@%0d", t), 32'(busy), 32'(exp_busy));
      chk($sformatf("gamma_rst@%0d", t), 32'(gamma_rst), 32'(t == G - 1));
      if (t == send_t) begin
        in_valid = 1'b1;
        in_value = v;
        in_mode  = mode;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{v: 5'd5,  mode: 1'b0, qlo: 5,  qhi: 14, busy: 1'b1};
    vecs[1] = '{v: 5'd2,  mode: 1'b1, qlo: 2,  qhi: 9,  busy: 1'b1};
    vecs[2] = '{v: 5'd10, mode: 1'b1, qlo: 10, qhi: 14, busy: 1'b1};
    vecs[3] = '{v: 5'd0,  mode: 1'b0, qlo: 0,  qhi: 14, busy: 1'b1};
    vecs[4] = '{v: 5'd14, mode: 1'b1, qlo: 14, qhi: 14, busy: 1'b1};
    vecs[5] = '{v: 5'd13, mode: 1'b1, qlo: 13, qhi: 14, busy: 1'b1};
    vecs[6] = '{v: 5'd15, mode: 1'b0, qlo: 1,  qhi: 0,  busy: 1'b0};
    vecs[7] = '{v: 5'd31, mode: 1'b1, qlo: 1,  qhi: 0,  busy: 1'b0};
    vecs[8] = '{v: 5'd7,  mode: 1'b0, qlo: 7,  qhi: 14, busy: 1'b1};

    grst = 1'b1; en = 1'b0; in_valid = 1'b0; in_value = '0; in_mode = 1'b0;
    #12;
    chk("rst_q", 32'(q), 0);
    chk("rst_tick", 32'(gamma_tick), 0);
    chk("rst_gamma_rst", 32'(gamma_rst), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    tick();
    grst = 1'b0;
    en   = 1'b1;

    // Table: the word sent in gamma i appears in gamma i+1.
    run_gamma(0, G, 1, 0, 1'b0, 0, vecs[0].v, vecs[0].mode);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) run_gamma(0, G, vecs[i].qlo, vecs[i].qhi, vecs[i].busy, 0, vecs[i+1].v, vecs[i+1].mode);
      else       run_gamma(0, G, vecs[i].qlo, vecs[i].qhi, vecs[i].busy, -1, '0, 1'b0);
    end
    run_gamma(0, G, 1, 0, 1'b0, -1, '0, 1'b0);

    // Backpressure: v=3 accepted at tick 0, v=7 held until pending drains.
    in_valid = 1'b1; in_value = 5'd3; in_mode = 1'b0;
    chk("bp_ready_hi", 32'(in_ready), 1);
    tick();
    chk("bp_ready_lo", 32'(in_ready), 0);
    in_value = 5'd7;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("bp_stall_cycles", 32'(n), 15);
    chk("bp_release_tick", 32'(gamma_tick), 0);
    run_gamma(0, G, 3, 14, 1'b1, 0, 5'd7, 1'b0);
    run_gamma(0, G, 7, 14, 1'b1, -1, '0, 1'b0);
    run_gamma(0, G, 1, 0, 1'b0, -1, '0, 1'b0);

    // Word accepted on the boundary edge skips the immediate gamma.
    run_gamma(0, G, 1, 0, 1'b0, G - 1, 5'd6, 1'b0);
    chk("bnd_pending", 32'(in_ready), 0);
    run_gamma(0, G, 1, 0, 1'b0, -1, '0, 1'b0);
    run_gamma(0, G, 6, 14, 1'b1, -1, '0, 1'b0);

    // en dropped at tick 8 of a step v=4 gamma.
    run_gamma(0, G, 1, 0, 1'b0, 0, 5'd4, 1'b0);
    run_gamma(0, 8, 4, 14, 1'b1, -1, '0, 1'b0);
    chk("en_pre_tick", 32'(gamma_tick), 8);
    chk("en_pre_q", 32'(q), 1);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("en_frz_tick%0d", k), 32'(gamma_tick), 8);
      chk($sformatf("en_frz_q%0d", k), 32'(q), 0);
      chk($sformatf("en_frz_busy%0d", k), 32'(busy), 1);
    end
    en = 1'b1;
    tick();
    chk("en_resume_tick", 32'(gamma_tick), 9);
    chk("en_resume_q", 32'(q), 1);
    run_gamma(9, G, 4, 14, 1'b1, 9, 5'd4, 1'b1);

    // grst at tick 7 of a pulse v=4 gamma, with a word waiting in pending.
    run_gamma(0, 7, 4, 11, 1'b1, 2, 5'd9, 1'b0);
    chk("grst_pre_q", 32'(q), 1);
    chk("grst_pre_ready", 32'(in_ready), 0);
    grst = 1'b1;
    #2;
    chk("grst_q_async", 32'(q), 0);
    chk("grst_tick", 32'(gamma_tick), 0);
    chk("grst_busy", 32'(busy), 0);
    chk("grst_ready", 32'(in_ready), 1);
    tick();
    grst = 1'b0;
    chk("grst_rel_ready", 32'(in_ready), 1);
    run_gamma(0, G, 1, 0, 1'b0, -1, '0, 1'b0);
    run_gamma(0, G, 1, 0, 1'b0, -1, '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
